cpu_loader: RTL and testbench



---
 rtl/cpu_loader_pkg.sv | 44 ++++
 rtl/cpu_loader_out_buf.sv | 49 ++++
 rtl/cpu_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// ============================================================================
// Module   : cpu_loader_pkg
// Purpose  : Shared state encoding, memory strides and phase sequencing helper
//            for the cpu_loader host-side memory master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_loader_pkg;

    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_I    = 3'd1,
        LOAD_D    = 3'd2,
        RUN       = 3'd3,
        DUMP_REQ  = 3'd4,
        DUMP_WAIT = 3'd5,
        DUMP_OUT  = 3'd6,
        DONE      = 3'd7
    } state_e;

    // nz = {dump, run, dmem, imem} non-zero flags; phases at or before cur are skipped.
    function automatic state_e next_phase(input state_e cur, input logic [3:0] nz);
        logic [3:0] m;
        m = nz;
        case (cur)
            LOAD_I:  m[0]   = 1'b0;
            LOAD_D:  m[1:0] = 2'b00;
            RUN:     m[2:0] = 3'b000;
            default: m      = nz;
        endcase
        if (m[0])      return LOAD_I;
        else if (m[1]) return LOAD_D;
        else if (m[2]) return RUN;
        else if (m[3]) return DUMP_REQ;
        else           return DONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_loader_out_buf.sv
// ============================================================================
// Module   : loader_out_buf
// Purpose  : One-entry 64-bit holding register with valid/ready handshake
//            used to present dumped data-memory words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_out_buf (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [63:0] out_data
);

    logic        valid_q, valid_d;
    logic [63:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/cpu_loader.sv
// ============================================================================
// Module   : cpu_loader
// Purpose  : Loads instruction/data memory images, runs the CPU for a set
//            number of cycles, then dumps a data-memory region. Optional
//            dump checksum output enabled by CPU_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_CNT_W = 9,
    parameter int DMEM_CNT_W = 10,
    parameter int RUN_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [IMEM_CNT_W-1:0] imem_words,
    input  logic [DMEM_CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic [DMEM_CNT_W-1:0] dump_base,
    input  logic [DMEM_CNT_W-1:0] dump_words,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  enable,
    output logic [63:0]           addr_ext,
    output logic                  wen_ext,
    output logic                  ren_ext,
    output logic [31:0]           wdata_ext,
    output logic [63:0]           addr_ext_2,
    output logic                  wen_ext_2,
    output logic                  ren_ext_2,
    output logic [63:0]           wdata_ext_2,
    input  logic [63:0]           rdata_ext_2
`ifdef CPU_LOADER_CHECKSUM_EN
    ,
    output logic [63:0]           dump_sum
`endif
);

    localparam int LD_W  = (IMEM_CNT_W > DMEM_CNT_W) ? IMEM_CNT_W : DMEM_CNT_W;
    localparam int CNT_W = (LD_W > RUN_W) ? LD_W : RUN_W;

    state_e                state_q, state_d;
    logic [IMEM_CNT_W-1:0] imem_q,  imem_d;
    logic [DMEM_CNT_W-1:0] dmem_q,  dmem_d;
    logic [RUN_W-1:0]      run_q,   run_d;
    logic [DMEM_CNT_W-1:0] base_q,  base_d;
    logic [DMEM_CNT_W-1:0] dwords_q, dwords_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic [CNT_W-1:0]      cnt_inc;
    logic [DMEM_CNT_W-1:0] dump_idx;
    logic [3:0]            nz_in, nz_q;
    logic                  buf_load;
    logic                  out_hs;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign dump_idx = base_q + cnt_q[DMEM_CNT_W-1:0];
    assign nz_in    = {|dump_words, |run_cycles, |dmem_words, |imem_words};
    assign nz_q     = {|dwords_q, |run_q, |dmem_q, |imem_q};
    assign out_hs   = (state_q == DUMP_OUT) && out_valid && out_ready;
    assign ren_ext  = 1'b0;

    always_comb begin
        state_d     = state_q;
        imem_d      = imem_q;
        dmem_d      = dmem_q;
        run_d       = run_q;
        base_d      = base_q;
        dwords_d    = dwords_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        enable      = 1'b0;
        done        = 1'b0;
        buf_load    = 1'b0;
        busy        = (state_q != IDLE);
        wen_ext     = 1'b0;
        addr_ext    = '0;
        wdata_ext   = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = '0;
        wdata_ext_2 = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    imem_d   = imem_words;
                    dmem_d   = dmem_words;
                    run_d    = run_cycles;
                    base_d   = dump_base;
                    dwords_d = dump_words;
                    cnt_d    = '0;
                    state_d  = next_phase(IDLE, nz_in);
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = 64'(cnt_q) * 64'(IMEM_STRIDE);
                    wdata_ext = in_data[31:0];
                    if (cnt_inc == CNT_W'(imem_q)) begin
                        cnt_d   = '0;
                        state_d = next_phase(LOAD_I, nz_q);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            LOAD_D: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = 64'(cnt_q) * 64'(DMEM_STRIDE);
                    wdata_ext_2 = in_data;
                    if (cnt_inc == CNT_W'(dmem_q)) begin
                        cnt_d   = '0;
                        state_d = next_phase(LOAD_D, nz_q);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RUN: begin
                enable = 1'b1;
                if (cnt_inc == CNT_W'(run_q)) begin
                    cnt_d   = '0;
                    state_d = next_phase(RUN, nz_q);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DUMP_REQ: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = 64'(dump_idx) * 64'(DMEM_STRIDE);
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                // read data arrives one cycle after the request
                buf_load = 1'b1;
                state_d  = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_hs) begin
                    if (cnt_inc == CNT_W'(dwords_q)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = DUMP_REQ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            imem_q   <= '0;
            dmem_q   <= '0;
            run_q    <= '0;
            base_q   <= '0;
            dwords_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            imem_q   <= imem_d;
            dmem_q   <= dmem_d;
            run_q    <= run_d;
            base_q   <= base_d;
            dwords_q <= dwords_d;
            cnt_q    <= cnt_d;
        end
    end

    loader_out_buf u_out_buf (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (buf_load),
        .load_data (rdata_ext_2),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

`ifdef CPU_LOADER_CHECKSUM_EN
    logic [63:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (out_hs) begin
            sum_d = {sum_q[62:0], sum_q[63]} ^ out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign dump_sum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_loader.sv
// ============================================================================
// Module   : tb_cpu_loader
// Purpose  : Self-checking bench for cpu_loader (job table + strobe scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [8:0]  imem_words;
    logic [9:0]  dmem_words;
    logic [31:0] run_cycles;
    logic [9:0]  dump_base;
    logic [9:0]  dump_words;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy, done, enable;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
`ifdef CPU_LOADER_CHECKSUM_EN
    logic [63:0] dump_sum;
`endif

    always #5 clk = ~clk;

    cpu_loader #(.IMEM_CNT_W(9), .DMEM_CNT_W(10), .RUN_W(32)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_words  (imem_words),
        .dmem_words  (dmem_words),
        .run_cycles  (run_cycles),
        .dump_base   (dump_base),
        .dump_words  (dump_words),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .enable      (enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
`ifdef CPU_LOADER_CHECKSUM_EN
        ,
        .dump_sum    (dump_sum)
`endif
    );

    typedef struct {
        int          imem;
        int          dmem;
        int          run;
        int          base;
        int          dwords;
        int          gap;
        int          ost;
        int          woff;
        int          restart_p;
        logic [63:0] tag;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ren = 0;
    int          n_hs  = 0;
    bit          mon_on = 1'b0;
    logic [63:0] mem_tag = '0;
    logic [63:0] lw [8];
    wr_t         exp_i[$];
    wr_t         exp_d[$];
    logic [63:0] exp_r[$];
    logic [63:0] exp_o[$];
    vec_t        tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Data memory model: registered read, one-cycle latency, address-tagged data.
    always @(posedge clk) begin
        if (ren_ext_2) rdata_ext_2 <= (addr_ext_2 >> 3) ^ mem_tag;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            wr_t  e;
            logic ov;
            ov = ($countones({wen_ext, wen_ext_2, ren_ext_2}) > 1);
            check("strobe_overlap", 64'(ov), 64'd0);
            check("strobe_while_enable", 64'(enable & (wen_ext | wen_ext_2 | ren_ext_2)), 64'd0);
            check("ren_ext", 64'(ren_ext), 64'd0);
            if (wen_ext) begin
                if (exp_i.size() == 0) check("wen_ext_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_i.pop_front();
                    check("imem_addr", addr_ext, e.addr);
                    check("imem_data", 64'(wdata_ext), e.data);
                end
            end
            if (wen_ext_2) begin
                if (exp_d.size() == 0) check("wen_ext_2_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_d.pop_front();
                    check("dmem_addr", addr_ext_2, e.addr);
                    check("dmem_data", wdata_ext_2, e.data);
                end
            end
            if (ren_ext_2) begin
                check("ren_order", 64'(n_ren), 64'(n_hs));
                n_ren++;
                if (exp_r.size() == 0) check("ren_ext_2_unexpected", 64'd1, 64'd0);
                else check("dump_addr", addr_ext_2, exp_r.pop_front());
            end
            if (out_valid) begin
                if (exp_o.size() == 0) check("out_valid_unexpected", 64'd1, 64'd0);
                else if (out_ready) begin
                    check("out_data_hs", out_data, exp_o.pop_front());
                    n_hs++;
                end else begin
                    check("out_data_stall", out_data, exp_o[0]);
                end
            end
        end
    end

    task automatic run_job(input vec_t v);
        int          p, fed, total, wait_cnt, en_cnt;
        bit          presenting, got_done;
        logic [63:0] cur, sum, d;
        wr_t         w;
        total = v.imem + v.dmem;
        sum   = '0;
        for (int i = 0; i < v.dwords; i++) begin
            d = 64'((v.base + i) % 1024) ^ v.tag;
            exp_r.push_back(64'((v.base + i) % 1024) * 64'd8);
            exp_o.push_back(d);
            sum = {sum[62:0], sum[63]} ^ d;
        end
        @(posedge clk); #1;
        mem_tag    = v.tag;
        imem_words = 9'(v.imem);
        dmem_words = 10'(v.dmem);
        run_cycles = 32'(v.run);
        dump_base  = 10'(v.base);
        dump_words = 10'(v.dwords);
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        start      = 1'b0;
        imem_words = '1;
        dmem_words = '1;
        run_cycles = 32'd77;
        dump_base  = 10'd3;
        dump_words = 10'd9;
        p = 1; fed = 0; wait_cnt = 0; en_cnt = 0;
        presenting = 1'b0; got_done = 1'b0; cur = '0;
        while (!got_done && p <= 300) begin
            start = (p == v.restart_p);
            if (!presenting && fed < total && ((p - 1) % (v.gap + 1)) == 0) begin
                presenting = 1'b1;
                cur = lw[(fed + v.woff) % 8];
                if (fed < v.imem) begin
                    w.addr = 64'(fed) * 64'd4;
                    w.data = {32'h0, cur[31:0]};
                    exp_i.push_back(w);
                end else begin
                    w.addr = 64'(fed - v.imem) * 64'd8;
                    w.data = cur;
                    exp_d.push_back(w);
                end
            end
            in_valid = presenting;
            in_data  = presenting ? cur : 64'h0BAD_0BAD_0BAD_0BAD;
            if (out_valid) begin
                out_ready = (wait_cnt >= v.ost);
                wait_cnt++;
            end else begin
                out_ready = 1'b0;
                wait_cnt  = 0;
            end
            @(negedge clk);
            if (p == 1 && (total + v.run + v.dwords) != 0) check("busy_p1", 64'(busy), 64'd1);
            if (enable) en_cnt++;
            if (in_valid && in_ready) begin
                presenting = 1'b0;
                fed++;
            end
            if (done) begin
                got_done = 1'b1;
                check("done_latency", 64'(p), 64'(v.exp_lat));
`ifdef CPU_LOADER_CHECKSUM_EN
                check("dump_sum", dump_sum, sum);
`endif
            end
            @(posedge clk); #1;
            p++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!got_done) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("done_pulse_end", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("enable_cycles", 64'(en_cnt), 64'(v.run));
        check("exp_i_left", 64'(exp_i.size()), 64'd0);
        check("exp_d_left", 64'(exp_d.size()), 64'd0);
        check("exp_r_left", 64'(exp_r.size()), 64'd0);
        check("exp_o_left", 64'(exp_o.size()), 64'd0);
        exp_i.delete(); exp_d.delete(); exp_r.delete(); exp_o.delete();
    endtask

    initial begin
        lw[0] = 64'hDEAD0000_00000013;
        lw[1] = 64'hBEEF0000_00100093;
        lw[2] = 64'hCAFE0000_00208113;
        lw[3] = 64'hAAAAAAAA_AAAAAAAA;
        lw[4] = 64'h55555555_55555555;
        lw[5] = 64'h01234567_89ABCDEF;
        lw[6] = 64'hFEDCBA98_76543210;
        lw[7] = 64'h0F0F0F0F_F0F0F0F0;
        //         imem dmem run base  dw gap ost woff rst tag                     lat
        tbl[0] = '{3,   0,   0,  0,    0, 0,  0,  0,   0,  64'h0,                  4};
        tbl[1] = '{0,   2,   0,  0,    0, 1,  0,  3,   0,  64'h0,                  4};
        tbl[2] = '{0,   0,   5,  0,    0, 0,  0,  0,   0,  64'h0,                  6};
        tbl[3] = '{0,   0,   0,  4,    2, 0,  4,  0,   0,  64'hA5A5_0000_0000_0000, 15};
        tbl[4] = '{0,   0,   0,  0,    0, 0,  0,  0,   0,  64'h0,                  1};
        tbl[5] = '{2,   1,   3,  1022, 3, 0,  1,  5,   0,  64'h5A5A_0000_0000_0000, 19};
        tbl[6] = '{1,   1,   0,  0,    0, 2,  0,  6,   0,  64'h0,                  5};
        tbl[7] = '{0,   0,   4,  0,    0, 0,  0,  0,   2,  64'h0,                  5};
        tbl[8] = '{0,   0,   0,  1,    2, 0,  0,  0,   0,  64'h0,                  7};

        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        imem_words = '0; dmem_words = '0; run_cycles = '0; dump_base = '0; dump_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   64'(in_ready),  64'd0);
        check("rst_out_valid",  64'(out_valid), 64'd0);
        check("rst_busy",       64'(busy),      64'd0);
        check("rst_done",       64'(done),      64'd0);
        check("rst_enable",     64'(enable),    64'd0);
        check("rst_strobes",    64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        check("rst_addr_ext",   addr_ext,       64'd0);
        check("rst_addr_ext_2", addr_ext_2,     64'd0);
        check("rst_wdata_ext",  64'(wdata_ext), 64'd0);
        check("rst_wdata_ext_2", wdata_ext_2,   64'd0);
        check("rst_out_data",   out_data,       64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 9; i++) run_job(tbl[i]);

        // Reset asserted during the second RUN cycle aborts the job.
        @(posedge clk); #1;
        run_cycles = 32'd10; imem_words = '0; dmem_words = '0; dump_words = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("abort_run_p1_enable", 64'(enable), 64'd1);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(negedge clk);
        check("abort_run_p2_enable", 64'(enable), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_enable", 64'(enable), 64'd0);
        check("abort_busy",   64'(busy),   64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        run_job(tbl[2]);
        run_job(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
